id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 17 +
 rtl/operand_bypass.sv | 28 ++
 rtl/id_ex_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths, zero-register index and decoded control type
package cpu_pkg;

   localparam int DEF_DATA_W   = 64;
   localparam int DEF_REG_W    = 5;
   localparam int DEF_ZERO_REG = 31;

   typedef struct packed {
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic       ALUSrc;
      logic       MemToReg;
      logic [2:0] ALUOp;
   } ctrl_t;

endpackage

// File: rtl/operand_bypass.sv
// rtl/operand_bypass.sv - one decode operand: zero register, write-back bypass, else regfile
module operand_bypass
   import cpu_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int REG_W    = DEF_REG_W,
   parameter int ZERO_REG = DEF_ZERO_REG
) (
   input  logic [REG_W-1:0]  src,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              wb_regwrite,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] operand
);

   localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

   // Zero register wins first, so a write-back aimed at it can never leak through.
   always_comb begin
      operand = rf_data;
      if (src == ZR)
         operand = '0;
      else if (wb_regwrite && (wb_rd == src) && (wb_rd != ZR))
         operand = wb_data;
   end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard stall and bubble insertion
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int REG_W    = DEF_REG_W,
   parameter int ZERO_REG = DEF_ZERO_REG
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rn,
   input  logic [REG_W-1:0]  id_rm,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [DATA_W-1:0] id_imm,
   input  ctrl_t             id_ctrl,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   input  logic              wb_regwrite,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              stall_out,
   output logic              ex_valid,
   output logic [REG_W-1:0]  ex_rn,
   output logic [REG_W-1:0]  ex_rm,
   output logic [REG_W-1:0]  ex_rd,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output ctrl_t             ex_ctrl,
   output logic [15:0]       stall_count
);

   localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              hazard;
   logic              bubble;

   operand_bypass #(.DATA_W(DATA_W), .REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_bypass_a (
      .src         (id_rn),
      .rf_data     (ReadData1),
      .wb_regwrite (wb_regwrite),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .operand     (op_a)
   );

   operand_bypass #(.DATA_W(DATA_W), .REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_bypass_b (
      .src         (id_rm),
      .rf_data     (ReadData2),
      .wb_regwrite (wb_regwrite),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .operand     (op_b)
   );

   assign hazard = ex_valid & ex_ctrl.MemRead & (ex_rd != ZR) & id_valid
                 & ((ex_rd == id_rn) | (ex_rd == id_rm));
   assign stall_out = hazard & ~flush;
   assign bubble    = flush | stall_out | ~id_valid;

   // A bubble clears MemRead, so one load can stall decode for at most one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= '0;
         ex_rn       <= ZR;
         ex_rm       <= ZR;
         ex_rd       <= ZR;
         ex_a        <= '0;
         ex_b        <= '0;
         ex_imm      <= '0;
         stall_count <= '0;
      end else begin
         if (stall_out && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
         if (bubble) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_rd    <= ZR;
         end else begin
            ex_valid <= 1'b1;
            ex_ctrl  <= id_ctrl;
            ex_rn    <= id_rn;
            ex_rm    <= id_rm;
            ex_rd    <= id_rd;
            ex_a     <= op_a;
            ex_b     <= op_b;
            ex_imm   <= id_imm;
         end
      end
   end

endmodule
